// File: rtl/elevator_controller.sv
// Single-car elevator motion/door controller.
// Collective (SCAN) scheduling over latched car and hall calls; travel and door
// dwell are timed by counters; served calls are dropped through one-hot clear masks.
module elevator_controller #(
    parameter int BUTTONS_WIDTH = 8,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32,
    localparam int FLOOR_W      = (BUTTONS_WIDTH > 1) ? $clog2(BUTTONS_WIDTH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
    input  logic [BUTTONS_WIDTH-1:0] active_out_up_levels,
    input  logic [BUTTONS_WIDTH-1:0] active_out_down_levels,
    output logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
    output logic [BUTTONS_WIDTH-1:0] inactivate_out_up_levels,
    output logic [BUTTONS_WIDTH-1:0] inactivate_out_down_levels,
    output logic [FLOOR_W-1:0]       current_floor,
    output logic                     moving_up,
    output logic                     moving_down,
    output logic                     door_open
);

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    state_t                   state_q, state_d;
    dir_t                     dir_q, dir_d;
    logic [FLOOR_W-1:0]       floor_q, floor_d;
    logic [TW-1:0]            tcnt_q, tcnt_d;
    logic [DW-1:0]            dcnt_q, dcnt_d;

    logic                     moving_up_q, moving_down_q, door_open_q;
    logic [BUTTONS_WIDTH-1:0] clr_in_q, clr_up_q, clr_dn_q;
    logic [BUTTONS_WIDTH-1:0] clr_in_d, clr_up_d, clr_dn_d;

    logic [BUTTONS_WIDTH-1:0] any_call;
    logic [FLOOR_W-1:0]       step_floor;
    logic                     arr_ahead, arr_hall_dir, arr_car;
    logic                     here_ahead, here_behind, here_opp_hall;
    logic                     idle_above, idle_below;

    function automatic logic any_above(input logic [BUTTONS_WIDTH-1:0] v,
                                       input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < BUTTONS_WIDTH; i++) begin
            if (v[i] && (FLOOR_W'(i) > f)) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [BUTTONS_WIDTH-1:0] v,
                                       input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < BUTTONS_WIDTH; i++) begin
            if (v[i] && (FLOOR_W'(i) < f)) r = 1'b1;
        end
        return r;
    endfunction

    assign any_call = active_in_levels | active_out_up_levels | active_out_down_levels;

    // Call terms at the current floor and at the floor about to be reached
    always_comb begin
        step_floor    = (state_q == MOVE_DOWN) ? (floor_q - FLOOR_W'(1))
                                               : (floor_q + FLOOR_W'(1));
        arr_car       = active_in_levels[step_floor];
        arr_hall_dir  = (dir_q == DIR_UP) ? active_out_up_levels[step_floor]
                                          : active_out_down_levels[step_floor];
        arr_ahead     = (dir_q == DIR_UP) ? any_above(any_call, step_floor)
                                          : any_below(any_call, step_floor);
        here_ahead    = (dir_q == DIR_UP) ? any_above(any_call, floor_q)
                                          : any_below(any_call, floor_q);
        here_behind   = (dir_q == DIR_UP) ? any_below(any_call, floor_q)
                                          : any_above(any_call, floor_q);
        here_opp_hall = (dir_q == DIR_UP) ? active_out_down_levels[floor_q]
                                          : active_out_up_levels[floor_q];
        idle_above    = any_above(any_call, floor_q);
        idle_below    = any_below(any_call, floor_q);
    end

    // Next-state logic for scheduling, travel timing and door dwell
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        floor_d = floor_q;
        tcnt_d  = '0;
        dcnt_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (any_call[floor_q]) begin
                    state_d = DOOR;
                    dir_d   = (active_out_up_levels[floor_q] | active_in_levels[floor_q] |
                               ~active_out_down_levels[floor_q]) ? DIR_UP : DIR_DOWN;
                end else if (idle_above) begin
                    state_d = MOVE_UP;
                    dir_d   = DIR_UP;
                end else if (idle_below) begin
                    state_d = MOVE_DOWN;
                    dir_d   = DIR_DOWN;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (tcnt_q == TW'(TRAVEL_CYCLES - 1)) begin
                    floor_d = step_floor;
                    if (arr_car || arr_hall_dir || !arr_ahead) begin
                        state_d = DOOR;
                        // Turn around only when nothing lies ahead and no same-direction
                        // hall call waits here, so that call is still the one cleared.
                        if (!arr_ahead && !arr_hall_dir)
                            dir_d = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            DOOR: begin
                if (dcnt_q == DW'(DOOR_CYCLES - 1)) begin
                    if (here_ahead) begin
                        state_d = (dir_q == DIR_UP) ? MOVE_UP : MOVE_DOWN;
                    end else if (here_opp_hall) begin
                        dir_d   = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                        state_d = DOOR;
                    end else if (here_behind) begin
                        dir_d   = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                        state_d = (dir_q == DIR_UP) ? MOVE_DOWN : MOVE_UP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear masks for the coming cycle: one-hot at the floor while the door is open
    always_comb begin
        clr_in_d = '0;
        clr_up_d = '0;
        clr_dn_d = '0;
        if (state_d == DOOR) begin
            clr_in_d[floor_d] = 1'b1;
            if (dir_d == DIR_UP) clr_up_d[floor_d] = 1'b1;
            else                 clr_dn_d[floor_d] = 1'b1;
        end
    end

    // State, position, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            dir_q         <= DIR_UP;
            floor_q       <= '0;
            tcnt_q        <= '0;
            dcnt_q        <= '0;
            moving_up_q   <= 1'b0;
            moving_down_q <= 1'b0;
            door_open_q   <= 1'b0;
            clr_in_q      <= '0;
            clr_up_q      <= '0;
            clr_dn_q      <= '0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            floor_q       <= floor_d;
            tcnt_q        <= tcnt_d;
            dcnt_q        <= dcnt_d;
            moving_up_q   <= (state_d == MOVE_UP);
            moving_down_q <= (state_d == MOVE_DOWN);
            door_open_q   <= (state_d == DOOR);
            clr_in_q      <= clr_in_d;
            clr_up_q      <= clr_up_d;
            clr_dn_q      <= clr_dn_d;
        end
    end

    assign inactivate_in_levels       = clr_in_q;
    assign inactivate_out_up_levels   = clr_up_q;
    assign inactivate_out_down_levels = clr_dn_q;
    assign current_floor              = floor_q;
    assign moving_up                  = moving_up_q;
    assign moving_down                = moving_down_q;
    assign door_open                  = door_open_q;

endmodule
